instruction_memory_loader: RTL and testbench
============================================

# instruction_memory_loader

Controller that sequences program loading into the instruction memory and then releases it for execution. It receives a byte stream from the debug UART receiver and assembles little-endian instruction words. Each word is presented to the memory with a correctly timed write pulse, and a word count is kept. After HALT is stored and a run command arrives, the block issues the one-cycle start pulse. It sits in the IF stage between the UART/debug unit and `instruction_memory`.

## Interface
Parameters:
- `REG_SIZE`, 32: instruction width in bits; must be a multiple of `BYTE_SIZE`.
- `BYTE_SIZE`, 8: width of a UART byte.
- `MEM_SIZE`, 1024: instruction memory size in bits; `TOTAL_INSTRUCTIONS = MEM_SIZE / REG_SIZE`.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_rx_valid`, in, 1: one-cycle strobe; `i_rx_data` holds a valid byte.
- `i_rx_data`, in, `BYTE_SIZE`: received byte.
- `i_run`, in, 1: run command from the debug unit; level or pulse.
- `o_instruction`, out, `REG_SIZE`: word sent to the memory's `i_instruction`.
- `o_instruction_write`, out, 1: one-cycle write request to the memory.
- `o_start`, out, 1: one-cycle start pulse to the memory.
- `o_loaded`, out, 1: HALT has been written; the program is ready.
- `o_running`, out, 1: start has been issued.
- `o_error`, out, 1: overflow, meaning the memory filled without HALT.
- `o_count`, out, `$clog2(TOTAL_INSTRUCTIONS)+1`: number of words written, HALT included.

## Operation
- Reset (`i_reset` = 0): all outputs are 0, the FSM is in LOAD, and the assembler byte index is 0.
- Byte assembler:
  - Bytes are accepted only while the FSM is in LOAD, WRITE or HOLD. Bytes in any other state are ignored.
  - The first byte of a word goes to bits [7:0], so the first byte is the LSB.
  - When the `REG_SIZE/BYTE_SIZE`-th byte is accepted, the full word is flagged.
- FSM states:
  - LOAD: waits for a full word.
    - If `o_count == TOTAL_INSTRUCTIONS-1` and the word is not `INSTRUCTION_HALT`, go to ERROR with no write.
    - Otherwise register the word into `o_instruction` and go to WRITE.
  - WRITE: `o_instruction_write` = 1; `o_count` increments by 1; go to HOLD.
  - HOLD: `o_instruction` is held so the memory samples it in its write state.
    - If the written word was HALT, go to LOADED.
    - Otherwise go to LOAD.
  - LOADED: `o_loaded` = 1. When `i_run` = 1, go to START.
  - START: `o_start` = 1 for one cycle; go to RUN.
  - RUN: `o_running` = 1. The block is terminal until reset.
  - ERROR: `o_error` = 1; no further writes. The block is terminal until reset.
- `o_instruction` changes only on LOAD→WRITE. It holds its value through WRITE, HOLD and the following LOAD.
- `i_run` has no effect outside LOADED; it is not remembered.
- A partial word left at HALT is impossible, because HALT completes a word.
- Bytes arriving after HALT are ignored.

## Timing
- The last byte of a word is accepted at edge n:
  - `o_instruction` is valid and `o_instruction_write` = 1 during cycle n+1.
  - The FSM is in HOLD during n+2.
  - The FSM is back in LOAD at n+3.
- The memory sees the write in cycle n+1 and samples `o_instruction` in n+2. The word is stable in both cycles.
- Back-to-back bytes, one per cycle: one word every 4 cycles. This always exceeds the 3-cycle WRITE/HOLD turnaround, so no back-pressure is required.
- HALT write pulse at cycle h: the earliest `o_start` is cycle h+3, which is LOADED plus one cycle of `i_run`. The memory is already ready to execute by then.
- `i_run` sampled high at edge r in LOADED: `o_start` is high during cycle r+1.
- Reset asserted mid-word or mid-write: the FSM and outputs clear immediately and asynchronously, and the partial word is discarded. The instruction memory must be reset in the same event; the top level drives the memory's active-high reset from `~i_reset`.

## Structure
- Shared header `instruction_memory_loader.vh` holds:
  - the state codes `STATE_LOADER_*` and `BITS_FOR_STATE_LOADER`;
  - the default parameters.
- `INSTRUCTION_HALT` (32'hFC00_0000) and `CLEAR(n)` are reused from the common header; they are not redefined.
- Sub-module `byte_to_word_assembler`, parameterised by `REG_SIZE` and `BYTE_SIZE`:
  - inputs: byte strobe, data, enable;
  - outputs: word, `word_valid` pulse;
  - it contains the shift register and the byte index.
- The FSM and counters stay in the top module.

## Test plan
- Reset: hold `i_reset` = 0 for 3 cycles. Expect all outputs 0, and after release `o_count` = 0 and no write pulse.
- Load the bytes 13,00,01,20, then 14,00,02,20, then 00,00,00,FC, one byte per cycle:
  - writes of 32'h2001_0013, 32'h2002_0014 and 32'hFC00_0000, each with a 1-cycle pulse;
  - `o_count` = 3 and `o_loaded` = 1 two cycles after the third pulse;
  - then `i_run` pulse → `o_start` = 1 exactly one cycle later, then `o_running` = 1.
- Overflow with `MEM_SIZE` = 128 (4 instructions): send 4 non-HALT words. Expect 3 writes, no 4th pulse, `o_error` = 1, and later bytes ignored.
- Run before load: assert `i_run` during LOAD. Expect no `o_start`. After HALT loads with `i_run` low, expect no `o_start` until `i_run` is raised.
- Reset mid-word: after 2 bytes, pulse `i_reset` low, then send a full HALT word. Expect one write of 32'hFC00_0000 and `o_count` = 1.
- Sparse bytes: 5 idle cycles between bytes. Expect identical words and a `o_instruction_write` pulse width of exactly 1 cycle.

Source files
------------

// File: rtl/instruction_memory_loader_pkg.sv
// instruction_memory_loader_pkg: shared loader state codes, default sizes and the HALT opcode
package instruction_memory_loader_pkg;
  localparam int DEFAULT_REG_SIZE = 32;
  localparam int DEFAULT_BYTE_SIZE = 8;
  localparam int DEFAULT_MEM_SIZE = 1024;
  localparam int BITS_FOR_STATE_LOADER = 3;
  localparam logic [31:0] INSTRUCTION_HALT = 32'hFC00_0000;
  typedef enum logic [BITS_FOR_STATE_LOADER-1:0] {
    STATE_LOADER_LOAD,
    STATE_LOADER_WRITE,
    STATE_LOADER_HOLD,
    STATE_LOADER_LOADED,
    STATE_LOADER_START,
    STATE_LOADER_RUN,
    STATE_LOADER_ERROR
  } loader_state_t;
endpackage

// File: rtl/instruction_memory_loader_if.sv
// instruction_memory_loader_if: UART byte input, run command and memory-side outputs of the loader
interface instruction_memory_loader_if
  import instruction_memory_loader_pkg::*;
#(
  parameter int REG_SIZE = DEFAULT_REG_SIZE,
  parameter int BYTE_SIZE = DEFAULT_BYTE_SIZE,
  parameter int MEM_SIZE = DEFAULT_MEM_SIZE
);
  localparam int COUNT_W = $clog2(MEM_SIZE / REG_SIZE) + 1;
  logic i_rx_valid;
  logic [BYTE_SIZE-1:0] i_rx_data;
  logic i_run;
  logic [REG_SIZE-1:0] o_instruction;
  logic o_instruction_write;
  logic o_start;
  logic o_loaded;
  logic o_running;
  logic o_error;
  logic [COUNT_W-1:0] o_count;
  modport master (
    input i_rx_valid, i_rx_data, i_run,
    output o_instruction, o_instruction_write, o_start, o_loaded, o_running, o_error, o_count
  );
  modport slave (
    output i_rx_valid, i_rx_data, i_run,
    input o_instruction, o_instruction_write, o_start, o_loaded, o_running, o_error, o_count
  );
endinterface

// File: rtl/instruction_memory_loader_byte_to_word_assembler.sv
// byte_to_word_assembler: packs LSB-first bytes into a word, flagging the word as its last byte arrives
module byte_to_word_assembler #(
  parameter int REG_SIZE = 32,
  parameter int BYTE_SIZE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [BYTE_SIZE-1:0] i_data,
  input  logic                 i_enable,
  output logic [REG_SIZE-1:0]  o_word,
  output logic                 o_word_valid
);
  localparam int BYTES = REG_SIZE / BYTE_SIZE;
  localparam int IDX_W = BYTES > 1 ? $clog2(BYTES) : 1;
  logic [REG_SIZE-BYTE_SIZE-1:0] shift;
  logic [IDX_W-1:0] idx;
  logic take;
  assign take = i_valid & i_enable;
  assign o_word = {i_data, shift};
  assign o_word_valid = take && idx == IDX_W'(BYTES - 1);
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      shift <= '0;
      idx <= '0;
    end else if (take) begin
      shift <= o_word[REG_SIZE-1:BYTE_SIZE];
      idx <= o_word_valid ? '0 : idx + IDX_W'(1);
    end
endmodule

// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader: assembles UART bytes into instructions, writes them to memory, then starts execution
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int REG_SIZE = DEFAULT_REG_SIZE,
  parameter int BYTE_SIZE = DEFAULT_BYTE_SIZE,
  parameter int MEM_SIZE = DEFAULT_MEM_SIZE
) (
  input logic i_clk,
  input logic i_reset,
  instruction_memory_loader_if.master bus
);
  localparam int TOTAL_INSTRUCTIONS = MEM_SIZE / REG_SIZE;
  localparam int COUNT_W = $clog2(TOTAL_INSTRUCTIONS) + 1;
  localparam logic [REG_SIZE-1:0] HALT = REG_SIZE'(INSTRUCTION_HALT);
  loader_state_t state, next_state;
  logic [REG_SIZE-1:0] word, instruction;
  logic [COUNT_W-1:0] count;
  logic word_valid, accept;
  assign accept = state inside {STATE_LOADER_LOAD, STATE_LOADER_WRITE, STATE_LOADER_HOLD};
  byte_to_word_assembler #(.REG_SIZE(REG_SIZE), .BYTE_SIZE(BYTE_SIZE)) u_assembler (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_valid(bus.i_rx_valid),
    .i_data(bus.i_rx_data),
    .i_enable(accept),
    .o_word(word),
    .o_word_valid(word_valid)
  );
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state <= STATE_LOADER_LOAD;
      instruction <= '0;
      count <= '0;
    end else begin
      state <= next_state;
      if (state == STATE_LOADER_LOAD && next_state == STATE_LOADER_WRITE) instruction <= word;
      if (state == STATE_LOADER_WRITE) count <= count + COUNT_W'(1);
    end
  // The last free slot is reserved for HALT; anything else there is an overflow.
  always_comb begin
    next_state = state;
    case (state)
      STATE_LOADER_LOAD:
        if (word_valid)
          next_state = (count == COUNT_W'(TOTAL_INSTRUCTIONS - 1) && word != HALT)
                       ? STATE_LOADER_ERROR : STATE_LOADER_WRITE;
      STATE_LOADER_WRITE:  next_state = STATE_LOADER_HOLD;
      STATE_LOADER_HOLD:   next_state = instruction == HALT ? STATE_LOADER_LOADED : STATE_LOADER_LOAD;
      STATE_LOADER_LOADED: next_state = bus.i_run ? STATE_LOADER_START : STATE_LOADER_LOADED;
      STATE_LOADER_START:  next_state = STATE_LOADER_RUN;
      default: ;
    endcase
  end
  assign bus.o_instruction = instruction;
  assign bus.o_count = count;
  assign bus.o_instruction_write = state == STATE_LOADER_WRITE;
  assign bus.o_loaded = state == STATE_LOADER_LOADED;
  assign bus.o_start = state == STATE_LOADER_START;
  assign bus.o_running = state == STATE_LOADER_RUN;
  assign bus.o_error = state == STATE_LOADER_ERROR;
endmodule

// File: tb/tb_instruction_memory_loader.sv
// tb_instruction_memory_loader: directed stimulus on a 32-word and a 4-word loader, checked against an event-time model
module tb_instruction_memory_loader;
  localparam int NONE = -1000;
  localparam logic [31:0] HALT = 32'hFC00_0000;
  logic clk = 0, rst_n = 0, rx_valid = 0, run = 0;
  logic [7:0] rx_data = '0;
  int tests = 0, fails = 0, e = 0;
  always #5 clk = ~clk;

  instruction_memory_loader_if #(.MEM_SIZE(1024)) ifa ();
  instruction_memory_loader_if #(.MEM_SIZE(128)) ifb ();
  assign ifa.i_rx_valid = rx_valid;
  assign ifa.i_rx_data = rx_data;
  assign ifa.i_run = run;
  assign ifb.i_rx_valid = rx_valid;
  assign ifb.i_rx_data = rx_data;
  assign ifb.i_run = run;
  instruction_memory_loader #(.MEM_SIZE(1024)) dut_a (.i_clk(clk), .i_reset(rst_n), .bus(ifa));
  instruction_memory_loader #(.MEM_SIZE(128)) dut_b (.i_clk(clk), .i_reset(rst_n), .bus(ifb));

  logic [31:0] act_instr[2], act_cnt[2];
  logic act_wr[2], act_start[2], act_loaded[2], act_running[2], act_error[2];
  assign act_instr[0] = ifa.o_instruction;
  assign act_instr[1] = ifb.o_instruction;
  assign act_cnt[0] = 32'(ifa.o_count);
  assign act_cnt[1] = 32'(ifb.o_count);
  assign act_wr[0] = ifa.o_instruction_write;
  assign act_wr[1] = ifb.o_instruction_write;
  assign act_start[0] = ifa.o_start;
  assign act_start[1] = ifb.o_start;
  assign act_loaded[0] = ifa.o_loaded;
  assign act_loaded[1] = ifb.o_loaded;
  assign act_running[0] = ifa.o_running;
  assign act_running[1] = ifb.o_running;
  assign act_error[0] = ifa.o_error;
  assign act_error[1] = ifb.o_error;

  // Model: remembers the edge at which each event happened and derives outputs from elapsed edges.
  int cap_total[2] = '{32, 4};
  logic [31:0] m_part[2], m_instr[2];
  int m_nb[2], m_cnt[2], m_w_edge[2], m_halt_edge[2], m_err_edge[2], m_start_edge[2];
  always @(posedge clk) begin
    e++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_part[d] = '0; m_instr[d] = '0; m_nb[d] = 0; m_cnt[d] = 0;
        m_w_edge[d] = NONE; m_halt_edge[d] = NONE; m_err_edge[d] = NONE; m_start_edge[d] = NONE;
      end else begin
        if (m_w_edge[d] == e - 1) m_cnt[d]++;
        if (run && m_halt_edge[d] != NONE && e >= m_halt_edge[d] + 3 && m_start_edge[d] == NONE)
          m_start_edge[d] = e;
        if (rx_valid && m_halt_edge[d] == NONE && m_err_edge[d] == NONE) begin
          m_part[d] = m_part[d] | (32'(rx_data) << (8 * m_nb[d]));
          m_nb[d]++;
          if (m_nb[d] == 4) begin
            if (m_cnt[d] == cap_total[d] - 1 && m_part[d] != HALT) m_err_edge[d] = e;
            else begin
              m_instr[d] = m_part[d];
              m_w_edge[d] = e;
              if (m_part[d] == HALT) m_halt_edge[d] = e;
            end
            m_part[d] = '0;
            m_nb[d] = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
    end
  endtask

  logic [31:0] cap0[$], cap1[$];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk("rst_instr", d, act_instr[d], 0);
        chk("rst_count", d, act_cnt[d], 0);
        chk("rst_flags", d, {27'd0, act_wr[d], act_start[d], act_loaded[d], act_running[d], act_error[d]}, 0);
      end else begin
        chk("instr", d, act_instr[d], m_instr[d]);
        chk("count", d, act_cnt[d], m_cnt[d]);
        chk("write", d, 32'(act_wr[d]), 32'(m_w_edge[d] == e));
        chk("start", d, 32'(act_start[d]), 32'(m_start_edge[d] == e));
        chk("loaded", d, 32'(act_loaded[d]), 32'(m_halt_edge[d] != NONE && e >= m_halt_edge[d] + 2 &&
                                               (m_start_edge[d] == NONE || e < m_start_edge[d])));
        chk("running", d, 32'(act_running[d]), 32'(m_start_edge[d] != NONE && e > m_start_edge[d]));
        chk("error", d, 32'(act_error[d]), 32'(m_err_edge[d] != NONE && e >= m_err_edge[d]));
      end
    end
    if (ifa.o_instruction_write) cap0.push_back(ifa.o_instruction);
    if (ifb.o_instruction_write) cap1.push_back(ifb.o_instruction);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset(input int n);
    rst_n = 0;
    idle(n);
    rst_n = 1;
    cap0.delete();
    cap1.delete();
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_valid = 1;
    @(posedge clk); #1;
    rx_valid = 0;
    idle(gap);
  endtask
  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  initial begin
    do_reset(3);
    idle(1);
    chk("post_reset_count", 0, act_cnt[0], 0);
    chk("post_reset_write", 0, 32'(act_wr[0]), 0);
    // Three-word program, back-to-back bytes, then run
    send_word(32'h2001_0013, 0);
    send_word(32'h2002_0014, 0);
    send_word(HALT, 0);
    chk("halt_pulse", 0, 32'(ifa.o_instruction_write), 1);
    idle(1);
    chk("halt_pulse_width", 0, 32'(ifa.o_instruction_write), 0);
    idle(1);
    chk("lit_loaded", 0, 32'(ifa.o_loaded), 1);
    chk("lit_count3", 0, 32'(ifa.o_count), 3);
    chk("lit_w0", 0, cap0[0], 32'h2001_0013);
    chk("lit_w1", 0, cap0[1], 32'h2002_0014);
    chk("lit_w2", 0, cap0[2], HALT);
    chk("lit_nwrites", 0, cap0.size(), 3);
    run = 1;
    idle(1);
    run = 0;
    chk("lit_start", 0, 32'(ifa.o_start), 1);
    idle(1);
    chk("lit_running", 0, 32'(ifa.o_running), 1);
    chk("lit_start_once", 0, 32'(ifa.o_start), 0);
    idle(3);
    // Run asserted before load, then HALT loaded with run low
    do_reset(2);
    run = 1;
    send_word(32'h0000_0001, 0);
    run = 0;
    send_word(HALT, 0);
    idle(6);
    chk("lit_no_early_start", 0, 32'(ifa.o_start | ifa.o_running), 0);
    chk("lit_loaded_wait", 0, 32'(ifa.o_loaded), 1);
    chk("lit_count2", 0, 32'(ifa.o_count), 2);
    run = 1;
    idle(1);
    run = 0;
    chk("lit_late_start", 0, 32'(ifa.o_start), 1);
    idle(2);
    // Overflow: dut1 holds only 4 words
    do_reset(2);
    for (int i = 0; i < 4; i++) send_word(32'h1000_0000 + i, 0);
    send_word(32'h0BAD_F00D, 0);
    idle(4);
    chk("lit_ovf_writes", 1, cap1.size(), 3);
    chk("lit_ovf_last", 1, cap1[2], 32'h1000_0002);
    chk("lit_ovf_error", 1, 32'(ifb.o_error), 1);
    chk("lit_ovf_count", 1, 32'(ifb.o_count), 3);
    chk("lit_big_writes", 0, cap0.size(), 5);
    chk("lit_big_error", 0, 32'(ifa.o_error), 0);
    // Reset in the middle of a word
    do_reset(2);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset(1);
    send_word(HALT, 0);
    idle(3);
    chk("lit_mid_writes", 0, cap0.size(), 1);
    chk("lit_mid_word", 0, cap0[0], HALT);
    chk("lit_mid_count", 0, 32'(ifa.o_count), 1);
    // Sparse bytes, 5 idle cycles between them
    do_reset(2);
    send_word(32'h2001_0013, 5);
    send_word(32'h2002_0014, 5);
    send_word(HALT, 5);
    idle(2);
    chk("lit_sparse_pulses", 0, cap0.size(), 3);
    chk("lit_sparse_w0", 0, cap0[0], 32'h2001_0013);
    chk("lit_sparse_w1", 0, cap0[1], 32'h2002_0014);
    chk("lit_sparse_w2", 0, cap0[2], HALT);
    chk("lit_sparse_count", 0, 32'(ifa.o_count), 3);
    chk("lit_sparse_loaded", 0, 32'(ifa.o_loaded), 1);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
